// File: rtl/scandbl_ctrl_if.sv
// Bus bundle between the Denise-side pixel timing, the scandoubler address
// controller and the line-buffer RAM ports.
interface scandbl_ctrl_if #(
  parameter int AW_LINE = 10,
  parameter int AW_BANK = 2
) ();
  logic                       wr_ce;
  logic                       rd_ce;
  logic                       sol;
  logic                       vsync_in;
  logic                       csync_n;
  logic                       rd_sol;
  logic                       clr_ovf;
  logic                       wr_en;
  logic [AW_BANK+AW_LINE-1:0] wr_addr;
  logic                       rd_en;
  logic [AW_BANK+AW_LINE-1:0] rd_addr;
  logic [AW_LINE-1:0]         line_len;
  logic                       hsync;
  logic                       vsync;
  logic                       ovf;

  modport master (
    output wr_ce, rd_ce, sol, vsync_in, csync_n, rd_sol, clr_ovf,
    input  wr_en, wr_addr, rd_en, rd_addr, line_len, hsync, vsync, ovf
  );

  modport slave (
    input  wr_ce, rd_ce, sol, vsync_in, csync_n, rd_sol, clr_ovf,
    output wr_en, wr_addr, rd_en, rd_addr, line_len, hsync, vsync, ovf
  );
endinterface

// File: rtl/scandbl_ctrl.sv
// Line-buffer address/sequence controller for the 2x scandoubler: writes each Denise line
// once, replays it twice at double rate, and derives VGA sync. Build option: SCANDBL_OVF_DET_EN.
module scandbl_ctrl #(
  parameter int AW_LINE   = 10,
  parameter int AW_BANK   = 2,
  parameter int BANK_LAG  = 2,
  parameter int HS_START  = 1,
  parameter int HS_END    = 68,
  parameter int VS_SAMPLE = 511
) (
  input  logic          clk,
  input  logic          arst_n,
  scandbl_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PASS_A = 2'd1,
    ST_PASS_B = 2'd2
  } rd_state_e;

  localparam logic [AW_LINE-1:0] PIX_ZERO  = AW_LINE'(0);
  localparam logic [AW_LINE-1:0] PIX_ONE   = AW_LINE'(1);
  localparam logic [AW_LINE-1:0] PIX_HS_S  = AW_LINE'(HS_START);
  localparam logic [AW_LINE-1:0] PIX_HS_E  = AW_LINE'(HS_END);
  localparam logic [AW_LINE-1:0] PIX_VS    = AW_LINE'(VS_SAMPLE);
  localparam logic [AW_BANK-1:0] BANK_ONE  = AW_BANK'(1);
  localparam logic [AW_BANK-1:0] BANK_LAGV = AW_BANK'(BANK_LAG);

  logic [AW_LINE-1:0] wr_pix_q, wr_pix_d;
  logic [AW_BANK-1:0] wr_bank_q, wr_bank_d;
  logic [AW_LINE-1:0] line_len_q, line_len_d;
  rd_state_e          rd_state_q, rd_state_d;
  logic [AW_LINE-1:0] rd_pix_q, rd_pix_d;
  logic [AW_BANK-1:0] rd_bank_q, rd_bank_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               cs_cap_q, cs_cap_d;

  // Write side: pixel counter and bank step on the 14 MHz enable
  always_comb begin
    wr_pix_d   = wr_pix_q;
    wr_bank_d  = wr_bank_q;
    line_len_d = line_len_q;
    if (bus.wr_ce) begin
      if (bus.sol) begin
        wr_pix_d   = PIX_ZERO;
        wr_bank_d  = wr_bank_q + BANK_ONE;
        line_len_d = wr_pix_q + PIX_ONE;
      end else begin
        wr_pix_d   = wr_pix_q + PIX_ONE;
      end
    end else begin
      wr_pix_d = wr_pix_q;
    end
  end

  // Read side: double-pass sequencer and sync generation on the 28 MHz enable
  always_comb begin
    rd_state_d = rd_state_q;
    rd_pix_d   = rd_pix_q;
    rd_bank_d  = rd_bank_q;
    hsync_d    = hsync_q;
    vsync_d    = vsync_q;
    cs_cap_d   = cs_cap_q;
    if (bus.rd_ce) begin
      // Sync decisions look at the pixel index before this step's update
      if (rd_state_q != ST_IDLE) begin
        if (rd_pix_q == PIX_VS) begin
          cs_cap_d = bus.csync_n;
        end else begin
          cs_cap_d = cs_cap_q;
        end
        if (rd_pix_q == PIX_HS_S) begin
          hsync_d = 1'b1;
        end else if (rd_pix_q == PIX_HS_E) begin
          hsync_d = 1'b0;
          vsync_d = ~cs_cap_q;
        end else begin
          hsync_d = hsync_q;
        end
      end else begin
        hsync_d = 1'b0;
        vsync_d = 1'b0;
      end

      if (bus.sol && bus.vsync_in) begin
        rd_state_d = ST_PASS_A;
        rd_bank_d  = wr_bank_q - BANK_LAGV;
        rd_pix_d   = PIX_ONE;
      end else begin
        case (rd_state_q)
          ST_IDLE: begin
            rd_state_d = ST_IDLE;
          end
          ST_PASS_A: begin
            if (bus.rd_sol) begin
              rd_state_d = ST_PASS_B;
              rd_pix_d   = PIX_ONE;
            end else begin
              rd_pix_d   = rd_pix_q + PIX_ONE;
            end
          end
          ST_PASS_B: begin
            if (bus.rd_sol) begin
              rd_state_d = ST_PASS_A;
              rd_bank_d  = rd_bank_q + BANK_ONE;
              rd_pix_d   = PIX_ONE;
            end else begin
              rd_pix_d   = rd_pix_q + PIX_ONE;
            end
          end
          default: begin
            rd_state_d = ST_IDLE;
          end
        endcase
      end
    end else begin
      rd_state_d = rd_state_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_pix_q   <= PIX_ZERO;
      wr_bank_q  <= {AW_BANK{1'b0}};
      line_len_q <= PIX_ZERO;
      rd_state_q <= ST_IDLE;
      rd_pix_q   <= PIX_ZERO;
      rd_bank_q  <= {AW_BANK{1'b0}};
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
      cs_cap_q   <= 1'b1;  // idle csync_n level, so no vsync before a real sample
    end else begin
      wr_pix_q   <= wr_pix_d;
      wr_bank_q  <= wr_bank_d;
      line_len_q <= line_len_d;
      rd_state_q <= rd_state_d;
      rd_pix_q   <= rd_pix_d;
      rd_bank_q  <= rd_bank_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      cs_cap_q   <= cs_cap_d;
    end
  end

`ifdef SCANDBL_OVF_DET_EN
  logic ovf_q, ovf_d, ovf_set_s;

  // Collision: a second-pass bank advance landing on the bank being written
  always_comb begin
    ovf_set_s = 1'b0;
    ovf_d     = ovf_q;
    if (bus.rd_ce && !(bus.sol && bus.vsync_in) && (rd_state_q == ST_PASS_B) && bus.rd_sol) begin
      ovf_set_s = ((rd_bank_q + BANK_ONE) == wr_bank_q);
    end else begin
      ovf_set_s = 1'b0;
    end
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Sticky collision flag register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.wr_en    = bus.wr_ce;
  assign bus.rd_en    = bus.rd_ce & (rd_state_q != ST_IDLE);
  assign bus.wr_addr  = {wr_bank_q, wr_pix_q};
  assign bus.rd_addr  = {rd_bank_q, rd_pix_q};
  assign bus.line_len = line_len_q;
  assign bus.hsync    = hsync_q;
  assign bus.vsync    = vsync_q;

endmodule

// File: tb/tb_scandbl_ctrl.sv
// Self-checking bench for scandbl_ctrl: directed scenarios plus randomized traffic
// compared against an integer-arithmetic model of the write/replay rules.
module tb_scandbl_ctrl;
  localparam int NPIX  = 1024;
  localparam int NBANK = 4;
  localparam int LAG   = 2;
  localparam int HS_S  = 1;
  localparam int HS_E  = 68;
  localparam int VS_S  = 511;
`ifdef SCANDBL_OVF_DET_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  scandbl_ctrl_if #(.AW_LINE(10), .AW_BANK(2)) bus ();

  scandbl_ctrl dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: plain integers, pass number 0=idle 1=first 2=second
  int m_wb, m_wp, m_len, m_pass, m_rb, m_rp;
  bit m_hs, m_vs, m_cap, m_ovf;
  bit seen_rd_en, exp_rd_en, seen_wr_en, exp_wr_en;

  function automatic void model_reset();
    m_wb = 0; m_wp = 0; m_len = 0; m_pass = 0; m_rb = 0; m_rp = 0;
    m_hs = 1'b0; m_vs = 1'b0; m_cap = 1'b1; m_ovf = 1'b0;
  endfunction

  function automatic void model_step(input bit wce, rce, s, vsi, cs, rs, clr);
    int old_wb;
    bit cap_old, hit;
    old_wb  = m_wb;
    cap_old = m_cap;
    hit     = 1'b0;
    if (wce) begin
      if (s) begin
        m_len = (m_wp + 1) % NPIX;
        m_wp  = 0;
        m_wb  = (m_wb + 1) % NBANK;
      end else begin
        m_wp = (m_wp + 1) % NPIX;
      end
    end
    if (rce) begin
      if (m_pass != 0) begin
        if (m_rp == VS_S) m_cap = cs;
        if (m_rp == HS_S) m_hs = 1'b1;
        else if (m_rp == HS_E) begin m_hs = 1'b0; m_vs = !cap_old; end
      end
      if (s && vsi) begin
        m_rb = (old_wb + NBANK - LAG) % NBANK; m_rp = 1; m_pass = 1;
      end else if (m_pass == 1 && rs) begin
        m_pass = 2; m_rp = 1;
      end else if (m_pass == 2 && rs) begin
        m_pass = 1; m_rb = (m_rb + 1) % NBANK; m_rp = 1; hit = (m_rb == old_wb);
      end else if (m_pass != 0) begin
        m_rp = (m_rp + 1) % NPIX;
      end
    end
    if (OVF_EN) begin
      if (hit) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
    end
  endfunction

  function automatic logic [36:0] exp_vec();
    logic [11:0] wa, ra;
    wa = 12'(m_wb * NPIX + m_wp);
    ra = 12'(m_rb * NPIX + m_rp);
    return {wa, ra, 10'(m_len), m_hs, m_vs, m_ovf};
  endfunction

  function automatic logic [36:0] dut_vec();
    return {bus.wr_addr, bus.rd_addr, bus.line_len, bus.hsync, bus.vsync, bus.ovf};
  endfunction

  // One clock: drive inputs, sample the combinational enables, step the model after the edge
  task automatic tick(input bit wce, rce, s, vsi, cs, rs, clr);
    bus.wr_ce = wce; bus.rd_ce = rce; bus.sol = s; bus.vsync_in = vsi;
    bus.csync_n = cs; bus.rd_sol = rs; bus.clr_ovf = clr;
    #2;
    seen_rd_en = bus.rd_en; seen_wr_en = bus.wr_en;
    exp_rd_en  = rce && (m_pass != 0);
    exp_wr_en  = wce;
    @(posedge clk);
    model_step(wce, rce, s, vsi, cs, rs, clr);
    #1;
  endtask

  task automatic do_reset();
    bus.wr_ce = 1'b0; bus.rd_ce = 1'b0; bus.sol = 1'b0; bus.vsync_in = 1'b0;
    bus.csync_n = 1'b1; bus.rd_sol = 1'b0; bus.clr_ovf = 1'b0;
    arst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 arst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.wr_ce = 1'b0; bus.rd_ce = 1'b1; bus.sol = 1'b0; bus.vsync_in = 1'b0;
    bus.csync_n = 1'b1; bus.rd_sol = 1'b0; bus.clr_ovf = 1'b0;
    arst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== 37'd0) begin
      failures++; $display("FAIL reset_outputs: got %h expected %h", dut_vec(), 37'd0);
    end
    checks++;
    if (bus.rd_en !== 1'b0 || bus.wr_en !== 1'b0) begin
      failures++; $display("FAIL reset_enables: got rd_en=%b wr_en=%b expected 0 0", bus.rd_en, bus.wr_en);
    end
    do_reset();
  endtask

  task automatic test_write_lines();
    logic [11:0] exp_wa;
    for (int ln = 0; ln < 3; ln++) begin
      for (int p = 0; p < 908; p++) begin
        tick(1'b1, 1'b0, (p == 0), 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.wr_addr !== exp_vec()[36:25] || seen_wr_en !== exp_wr_en) begin
          failures++;
          $display("FAIL write_step: got addr=%h wr_en=%b expected addr=%h wr_en=%b",
                   bus.wr_addr, seen_wr_en, exp_vec()[36:25], exp_wr_en);
        end
      end
    end
    exp_wa = {2'd3, 10'd907};
    checks++;
    if (bus.wr_addr !== exp_wa || bus.line_len !== 10'd908) begin
      failures++; $display("FAIL write_3_lines: got addr=%h len=%0d expected addr=%h len=908",
                           bus.wr_addr, bus.line_len, exp_wa);
    end
    for (int i = 0; i < 200; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_wa = {2'd3, 10'd83};
    checks++;
    if (bus.wr_addr !== exp_wa) begin
      failures++; $display("FAIL write_pixel_wrap: got %h expected %h", bus.wr_addr, exp_wa);
    end
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.wr_addr !== 12'd0 || bus.line_len !== 10'd84) begin
      failures++; $display("FAIL write_bank_wrap: got addr=%h len=%0d expected addr=000 len=84",
                           bus.wr_addr, bus.line_len);
    end
  endtask

  task automatic test_resync();
    logic [11:0] exp_ra;
    do_reset();
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    exp_ra = {2'd3, 10'd1};
    checks++;
    if (bus.rd_addr !== exp_ra || seen_rd_en !== 1'b0) begin
      failures++; $display("FAIL resync: got rd_addr=%h rd_en=%b expected rd_addr=%h rd_en=0",
                           bus.rd_addr, seen_rd_en, exp_ra);
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    exp_ra = {2'd3, 10'd2};
    checks++;
    if (bus.rd_addr !== exp_ra || seen_rd_en !== 1'b1) begin
      failures++; $display("FAIL first_pass_step: got rd_addr=%h rd_en=%b expected rd_addr=%h rd_en=1",
                           bus.rd_addr, seen_rd_en, exp_ra);
    end
  endtask

  task automatic test_double_pass();
    logic [11:0] exp_ra;
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_ra = {2'd3, 10'd2};
    checks++;
    if (bus.rd_addr !== exp_ra) begin
      failures++; $display("FAIL rd_sol_without_ce: got %h expected %h", bus.rd_addr, exp_ra);
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_ra = {2'd3, 10'd1};
    checks++;
    if (bus.rd_addr !== exp_ra) begin
      failures++; $display("FAIL second_pass_start: got %h expected %h", bus.rd_addr, exp_ra);
    end
    repeat (3) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_ra = {2'd0, 10'd1};
    checks++;
    if (bus.rd_addr !== exp_ra || bus.ovf !== 1'b0) begin
      failures++; $display("FAIL bank_advance: got rd_addr=%h ovf=%b expected rd_addr=%h ovf=0",
                           bus.rd_addr, bus.ovf, exp_ra);
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    exp_ra = {2'd1, 10'd1};
    checks++;
    if (bus.rd_addr !== exp_ra || bus.ovf !== OVF_EN) begin
      failures++; $display("FAIL collision_set: got rd_addr=%h ovf=%b expected rd_addr=%h ovf=%b",
                           bus.rd_addr, bus.ovf, exp_ra, OVF_EN);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (bus.ovf !== 1'b0) begin
      failures++; $display("FAIL collision_clear: got %b expected 0", bus.ovf);
    end
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if (bus.ovf !== OVF_EN) begin
      failures++; $display("FAIL set_beats_clear: got %b expected %b", bus.ovf, OVF_EN);
    end
    checks++;
    if (dut_vec() !== exp_vec()) begin
      failures++; $display("FAIL double_pass_state: got %h expected %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_sync();
    bit cs, exp_hs;
    int p;
    do_reset();
    tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2120; i++) begin
      cs = (i < 1024) ? 1'b0 : 1'b1;
      tick(1'b0, 1'b1, 1'b0, 1'b0, cs, 1'b0, 1'b0);
      p = (1 + i) % NPIX;
      exp_hs = (p >= HS_S && p < HS_E);
      checks++;
      if (bus.hsync !== exp_hs) begin
        failures++; $display("FAIL hsync_window pix=%0d: got %b expected %b", p, bus.hsync, exp_hs);
      end
      if (i == 67 || i == 1091 || i == 2115) begin
        checks++;
        if (bus.vsync !== (i == 1091)) begin
          failures++; $display("FAIL vsync_update i=%0d: got %b expected %b", i, bus.vsync, (i == 1091));
        end
      end
    end
  endtask

  task automatic test_random();
    bit wce, rce, s, vsi, cs, rs, clr;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      wce = ($urandom_range(0, 2) == 0);
      rce = ($urandom_range(0, 1) == 0);
      s   = ($urandom_range(0, 31) == 0);
      vsi = ($urandom_range(0, 2) == 0);
      cs  = ($urandom_range(0, 3) != 0);
      rs  = ($urandom_range(0, 29) == 0);
      clr = ($urandom_range(0, 63) == 0);
      tick(wce, rce, s, vsi, cs, rs, clr);
      checks++;
      if (dut_vec() !== exp_vec() || seen_rd_en !== exp_rd_en || seen_wr_en !== exp_wr_en) begin
        failures++;
        $display("FAIL random_step %0d: got %h rd_en=%b wr_en=%b expected %h rd_en=%b wr_en=%b",
                 i, dut_vec(), seen_rd_en, seen_wr_en, exp_vec(), exp_rd_en, exp_wr_en);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (10) tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.wr_ce = 1'b0; bus.rd_ce = 1'b1; bus.sol = 1'b0;
    #2 arst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== 37'd0 || bus.rd_en !== 1'b0) begin
      failures++; $display("FAIL async_reset: got %h rd_en=%b expected 0 rd_en=0", dut_vec(), bus.rd_en);
    end
    #2 arst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b1, 1'b0, (i % 2 == 0), 1'b1, 1'b1, 1'b0);
      checks++;
      if (seen_rd_en !== 1'b0) begin
        failures++; $display("FAIL rd_en_after_reset %0d: got %b expected 0", i, seen_rd_en);
      end
    end
    tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (seen_rd_en !== 1'b1 || dut_vec() !== exp_vec()) begin
      failures++; $display("FAIL restart_after_resync: got rd_en=%b %h expected rd_en=1 %h",
                           seen_rd_en, dut_vec(), exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_write_lines();
    test_resync();
    test_double_pass();
    test_sync();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
